// File: rtl/fx_pkg.sv
// Fixed-point execution unit shared definitions:
// opcodes, unit/format codes and CR field packing.
package fx_pkg;

  localparam logic [5:0] MULLI   = 6'd7;
  localparam logic [5:0] SUBFIC  = 6'd8;
  localparam logic [5:0] CMPLI   = 6'd10;
  localparam logic [5:0] CMPI    = 6'd11;
  localparam logic [5:0] ADDIC   = 6'd12;
  localparam logic [5:0] ADDIC_R = 6'd13;
  localparam logic [5:0] ADDI    = 6'd14;
  localparam logic [5:0] ADDIS   = 6'd15;
  localparam logic [5:0] ORI     = 6'd24;
  localparam logic [5:0] ORIS    = 6'd25;
  localparam logic [5:0] XORI    = 6'd26;
  localparam logic [5:0] XORIS   = 6'd27;
  localparam logic [5:0] ANDI_R  = 6'd28;
  localparam logic [5:0] ANDIS_R = 6'd29;

  typedef enum logic [1:0] {
    FU_FX = 2'd0,
    FU_LS = 2'd1,
    FU_BR = 2'd2,
    FU_FP = 2'd3
  } fu_code_e;

  typedef enum logic [1:0] {
    FMT_D  = 2'd0,
    FMT_DS = 2'd1,
    FMT_X  = 2'd2,
    FMT_XO = 2'd3
  } fmt_e;

  // CR field bits in architectural order: LT is the
  // leftmost (bit 0 in big-endian numbering).
  localparam int CR_LT = 3;
  localparam int CR_GT = 2;
  localparam int CR_EQ = 1;
  localparam int CR_SO = 0;

  function automatic logic [3:0] cr_pack(
    input logic lt,
    input logic gt,
    input logic eq,
    input logic so
  );
    logic [3:0] v;
    v = '0;
    v[CR_LT] = lt;
    v[CR_GT] = gt;
    v[CR_EQ] = eq;
    v[CR_SO] = so;
    return v;
  endfunction

endpackage

// File: rtl/fx_if.sv
// Issue and writeback bundle between dispatch,
// the fixed-point unit and the writeback arbiter.
interface fx_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) ();
  logic                      valid_i;
  logic                      ready_o;
  logic [1:0]                functionalUnitCode_i;
  logic [5:0]                opCode_i;
  logic [REG_ADDR_WIDTH-1:0] rtAddr_i;
  logic [2:0]                bf_i;
  logic [DATA_WIDTH-1:0]     operand_i;
  logic [DATA_WIDTH-1:0]     imm_i;
  logic                      wbValid_o;
  logic                      wbReady_i;
  logic [REG_ADDR_WIDTH-1:0] wbAddr_o;
  logic [DATA_WIDTH-1:0]     wbData_o;
  logic                      crValid_o;
  logic [2:0]                crField_o;
  logic [3:0]                crData_o;
  logic                      xerCa_o;
  logic                      xerCa32_o;
  logic                      xerSo_o;
  logic                      illegal_o;

  modport master (
    output valid_i, functionalUnitCode_i, opCode_i,
    output rtAddr_i, bf_i, operand_i, imm_i, wbReady_i,
    input  ready_o, wbValid_o, wbAddr_o, wbData_o,
    input  crValid_o, crField_o, crData_o,
    input  xerCa_o, xerCa32_o, xerSo_o, illegal_o
  );

  modport slave (
    input  valid_i, functionalUnitCode_i, opCode_i,
    input  rtAddr_i, bf_i, operand_i, imm_i, wbReady_i,
    output ready_o, wbValid_o, wbAddr_o, wbData_o,
    output crValid_o, crField_o, crData_o,
    output xerCa_o, xerCa32_o, xerSo_o, illegal_o
  );
endinterface

// File: rtl/fx_mul_seq.sv
// Fixed-latency multiplier sequencer for mulli;
// done is high in the last busy cycle.
module fx_mul_seq #(
  parameter int DATA_WIDTH  = 64,
  parameter int MUL_LATENCY = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);
  localparam int CW = $clog2(MUL_LATENCY);

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      busy <= 1'b0;
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(MUL_LATENCY - 1);
      a_q  <= a;
      b_q  <= b;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  assign done = busy && (cnt == '0);

  // Low half of a product is sign-agnostic.
  assign product = a_q * b_q;

endmodule

// File: rtl/fx_exec_unit.sv
// D-form fixed-point execute stage with issue handshake,
// registered writeback, CR results and XER carry state.
module fx_exec_unit
  import fx_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MUL_LATENCY    = 4,
  parameter int FX_UNIT_CODE   = 0
) (
  input logic clock_i,
  input logic reset_i,
  fx_if.slave bus
);
  localparam int DW = DATA_WIDTH;

  logic [DW-1:0] a, b, res;
  logic [DW:0]   sum_w, sub_w;
  logic          c32_add, c32_sub;
  logic [5:0]    op;
  logic          ready, accept;
  logic          wr, rec, cmp, xer_wr, ill, mul_op;
  logic          ca_d, ca32_d;
  logic [3:0]    cr_d;

  logic                      mul_busy, mul_done;
  logic [DW-1:0]             mul_prod;
  logic [REG_ADDR_WIDTH-1:0] mul_rt;

  logic                      wb_valid;
  logic [DW-1:0]             wb_data;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic                      cr_valid, ill_q;
  logic [2:0]                cr_field;
  logic [3:0]                cr_data;
  logic                      ca_q, ca32_q, so_q;

  assign a  = bus.operand_i;
  assign b  = bus.imm_i;
  assign op = bus.opCode_i;

  assign ready = !reset_i && !mul_busy &&
                 (!wb_valid || bus.wbReady_i);
  assign accept = bus.valid_i && ready &&
    (bus.functionalUnitCode_i == 2'(FX_UNIT_CODE));

  assign sum_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, ~a} + {1'b0, b} + (DW+1)'(1);

  // Carry into bit 32 recovered from the full-width sum.
  if (DW > 32) begin : g_c32
    assign c32_add = sum_w[32] ^ a[32] ^ b[32];
    assign c32_sub = sub_w[32] ^ ~a[32] ^ b[32];
  end else begin : g_c32_eq
    assign c32_add = sum_w[DW];
    assign c32_sub = sub_w[DW];
  end

  always_comb begin
    res    = '0;
    wr     = 1'b0;
    rec    = 1'b0;
    cmp    = 1'b0;
    xer_wr = 1'b0;
    ill    = 1'b0;
    mul_op = 1'b0;
    ca_d   = 1'b0;
    ca32_d = 1'b0;
    cr_d   = '0;
    unique case (1'b1)
      (op == ADDI) || (op == ADDIS): begin
        res = sum_w[DW-1:0];
        wr  = 1'b1;
      end
      (op == ADDIC) || (op == ADDIC_R): begin
        res    = sum_w[DW-1:0];
        wr     = 1'b1;
        xer_wr = 1'b1;
        ca_d   = sum_w[DW];
        ca32_d = c32_add;
        rec    = (op == ADDIC_R);
      end
      (op == SUBFIC): begin
        res    = sub_w[DW-1:0];
        wr     = 1'b1;
        xer_wr = 1'b1;
        ca_d   = sub_w[DW];
        ca32_d = c32_sub;
      end
      (op == ORI) || (op == ORIS): begin
        res = a | b;
        wr  = 1'b1;
      end
      (op == XORI) || (op == XORIS): begin
        res = a ^ b;
        wr  = 1'b1;
      end
      (op == ANDI_R) || (op == ANDIS_R): begin
        res = a & b;
        wr  = 1'b1;
        rec = 1'b1;
      end
      (op == CMPI): begin
        cmp  = 1'b1;
        cr_d = cr_pack($signed(a) < $signed(b),
                       $signed(a) > $signed(b),
                       a == b, so_q);
      end
      (op == CMPLI): begin
        cmp  = 1'b1;
        cr_d = cr_pack(a < b, a > b, a == b, so_q);
      end
      (op == MULLI): mul_op = 1'b1;
      default:       ill    = 1'b1;
    endcase
    if (rec) begin
      cr_d = cr_pack(res[DW-1],
                     !res[DW-1] && (res != '0),
                     res == '0, so_q);
    end
  end

  fx_mul_seq #(
    .DATA_WIDTH  (DW),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start   (accept && mul_op),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_addr  <= '0;
      mul_rt   <= '0;
      cr_valid <= 1'b0;
      cr_field <= '0;
      cr_data  <= '0;
      ill_q    <= 1'b0;
      ca_q     <= 1'b0;
      ca32_q   <= 1'b0;
      so_q     <= 1'b0;
    end else begin
      cr_valid <= 1'b0;
      ill_q    <= accept && ill;
      if (accept && mul_op) mul_rt <= bus.rtAddr_i;
      if (accept && (rec || cmp)) begin
        cr_valid <= 1'b1;
        cr_field <= cmp ? bus.bf_i : 3'd0;
        cr_data  <= cr_d;
      end
      if (accept && xer_wr) begin
        ca_q   <= ca_d;
        ca32_q <= ca32_d;
      end
      if (accept && wr) begin
        wb_valid <= 1'b1;
        wb_data  <= res;
        wb_addr  <= bus.rtAddr_i;
      end else if (mul_done) begin
        wb_valid <= 1'b1;
        wb_data  <= mul_prod;
        wb_addr  <= mul_rt;
      end else if (bus.wbReady_i) begin
        wb_valid <= 1'b0;
      end
    end
  end

  assign bus.ready_o   = ready;
  assign bus.wbValid_o = wb_valid;
  assign bus.wbData_o  = wb_data;
  assign bus.wbAddr_o  = wb_addr;
  assign bus.crValid_o = cr_valid;
  assign bus.crField_o = cr_field;
  assign bus.crData_o  = cr_data;
  assign bus.xerCa_o   = ca_q;
  assign bus.xerCa32_o = ca32_q;
  assign bus.xerSo_o   = so_q;
  assign bus.illegal_o = ill_q;

endmodule
